// File: rtl/gol_pkg.sv
// Shared types and constants for the Life-like row engine.
// Configuration macro used by the engine: GOL_TORUS_EN (toroidal wrap-around grid).
package gol_pkg;

    // Conway's Life as birth/survive masks (bit n = neighbour count n).
    localparam logic [8:0] GOL_B3S23_BIRTH   = 9'b000001000;
    localparam logic [8:0] GOL_B3S23_SURVIVE = 9'b000001100;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StFlush
    } gol_state_e;

    // Moore neighbour count, 0..8.
    typedef logic [3:0] nbr_cnt_t;

    function automatic nbr_cnt_t count_nbrs(input logic [7:0] nbrs);
        nbr_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + nbr_cnt_t'(nbrs[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Combinational next-state rule for one cell: counts live neighbours and
// looks the count up in the survive mask (live centre) or birth mask (dead centre).
module gol_cell_rule
    import gol_pkg::*;
(
    input  logic       centre,
    input  logic [7:0] nbrs,
    input  logic [8:0] birth_mask,
    input  logic [8:0] survive_mask,
    output logic       next_alive
);

    nbr_cnt_t cnt;

    assign cnt        = count_nbrs(nbrs);
    assign next_alive = centre ? survive_mask[cnt] : birth_mask[cnt];

endmodule

// File: rtl/gol_row_engine.sv
// Streaming Life-like row engine: takes one grid row per handshake and emits the
// next generation one row per handshake, one row behind the input.
// Configuration macro: GOL_TORUS_EN selects a toroidal grid (rows 0 and 1 are kept
// in a wrap buffer and emitted last); undefined gives a dead boundary.
module gol_row_engine
    import gol_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned H = 16,
    localparam int unsigned IW = $clog2(H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    birth_mask,
    input  logic [8:0]    survive_mask,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_row,
    output logic [IW-1:0] out_idx,
    output logic          out_last
);

    localparam logic [IW-1:0] LastRow = IW'(H - 1);

    gol_state_e    state_q;
    logic [W-1:0]  prev1_q;   // most recently accepted row
    logic [W-1:0]  prev2_q;   // row before that (zero while row -1 is implied)
`ifdef GOL_TORUS_EN
    logic [W-1:0]  wrap0_q;   // row 0, needed again for rows H-1 and 0
    logic [W-1:0]  wrap1_q;   // row 1, needed again for row 0
`endif
    logic [8:0]    birth_q;
    logic [8:0]    survive_q;
    logic [IW-1:0] row_q;     // RUN: index of next input row; FLUSH: next output row
    logic          sent_q;    // FLUSH: final row of the frame has been loaded

    logic          out_free;
    logic          accept;
    logic [W-1:0]  above;
    logic [W-1:0]  centre;
    logic [W-1:0]  below;
    logic [W+1:0]  ext_above;
    logic [W+1:0]  ext_centre;
    logic [W+1:0]  ext_below;
    logic [W-1:0]  next_row;

    assign out_free = !out_valid || out_ready;
    assign in_ready = ((state_q == StFill) || (state_q == StRun)) && out_free;
    assign accept   = in_valid && in_ready;

    // Select the three rows (above, centre, below) feeding the rule array.
    always_comb begin
        above  = prev2_q;
        centre = prev1_q;
        below  = in_row;
        if (state_q == StFlush) begin
`ifdef GOL_TORUS_EN
            if (row_q == LastRow) begin
                below = wrap0_q;
            end else begin
                above  = prev1_q;
                centre = wrap0_q;
                below  = wrap1_q;
            end
`else
            below = '0;
`endif
        end
    end

    // Pad each row with column -1 (bit 0) and column W (bit W+1).
    always_comb begin
`ifdef GOL_TORUS_EN
        ext_above  = {above[0], above, above[W-1]};
        ext_centre = {centre[0], centre, centre[W-1]};
        ext_below  = {below[0], below, below[W-1]};
`else
        ext_above  = {1'b0, above, 1'b0};
        ext_centre = {1'b0, centre, 1'b0};
        ext_below  = {1'b0, below, 1'b0};
`endif
    end

    for (genvar c = 0; c < W; c++) begin : g_cell
        gol_cell_rule u_cell (
            .centre      (centre[c]),
            .nbrs        ({ext_above[c+2:c], ext_centre[c+2], ext_centre[c],
                           ext_below[c+2:c]}),
            .birth_mask  (birth_q),
            .survive_mask(survive_q),
            .next_alive  (next_row[c])
        );
    end

    // FSM, line buffers, latched masks and the registered output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prev1_q   <= '0;
            prev2_q   <= '0;
`ifdef GOL_TORUS_EN
            wrap0_q   <= '0;
            wrap1_q   <= '0;
`endif
            birth_q   <= '0;
            survive_q <= '0;
            row_q     <= '0;
            sent_q    <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                StIdle: state_q <= StFill;
                StFill: begin
                    if (accept) begin
                        prev1_q   <= in_row;
                        prev2_q   <= '0;
`ifdef GOL_TORUS_EN
                        wrap0_q   <= in_row;
`endif
                        birth_q   <= birth_mask;
                        survive_q <= survive_mask;
                        row_q     <= IW'(1);
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (accept) begin
                        prev2_q <= prev1_q;
                        prev1_q <= in_row;
`ifdef GOL_TORUS_EN
                        // Row 0 needs row H-1 above it, so it is emitted at the end.
                        if (row_q == IW'(1)) begin
                            wrap1_q <= in_row;
                        end else begin
                            out_valid <= 1'b1;
                            out_row   <= next_row;
                            out_idx   <= row_q - IW'(1);
                            out_last  <= 1'b0;
                        end
`else
                        out_valid <= 1'b1;
                        out_row   <= next_row;
                        out_idx   <= row_q - IW'(1);
                        out_last  <= 1'b0;
`endif
                        if (row_q == LastRow) begin
                            state_q <= StFlush;
                            sent_q  <= 1'b0;
                        end else begin
                            row_q <= row_q + IW'(1);
                        end
                    end
                end
                StFlush: begin
                    if (out_valid && out_ready && out_last) begin
                        state_q <= StFill;
                        row_q   <= '0;
                        sent_q  <= 1'b0;
                    end else if (out_free && !sent_q) begin
                        out_valid <= 1'b1;
                        out_row   <= next_row;
                        out_idx   <= row_q;
`ifdef GOL_TORUS_EN
                        if (row_q == LastRow) begin
                            out_last <= 1'b0;
                            row_q    <= '0;
                        end else begin
                            out_last <= 1'b1;
                            sent_q   <= 1'b1;
                        end
`else
                        out_last <= 1'b1;
                        sent_q   <= 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_row_engine.sv
// Self-checking bench for gol_row_engine (8x8 grid) against a cell-by-cell
// reference model of the automaton.
module tb_gol_row_engine;
    import gol_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 8;
    localparam int unsigned IW = $clog2(H);

    typedef logic [W-1:0] grid_t [H];
    typedef struct {
        logic [W-1:0] row;
        int           idx;
        bit           last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    birth_mask = '0;
    logic [8:0]    survive_mask = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_row = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_row;
    logic [IW-1:0] out_idx;
    logic          out_last;

    gol_row_engine #(.W(W), .H(H)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .birth_mask  (birth_mask),
        .survive_mask(survive_mask),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_idx     (out_idx),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    exp_t          exp_q[$];
    exp_t          e;
    logic [W-1:0]  cap [H];
    bit            ignore_out = 1'b1;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit            hold_pending = 1'b0;
    logic [W-1:0]  held_row;
    logic [IW-1:0] held_idx;
    logic          held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference model: state of one cell, honouring the grid boundary.
    function automatic bit cell_at(input grid_t g, input int r, input int c);
`ifdef GOL_TORUS_EN
        r = (r + int'(H)) % int'(H);
        c = (c + int'(W)) % int'(W);
`else
        if (r < 0 || r >= int'(H) || c < 0 || c >= int'(W)) return 1'b0;
`endif
        return g[r][c];
    endfunction

    task automatic next_gen(input grid_t g, input logic [8:0] b, input logic [8:0] s,
                            output grid_t n);
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                int cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) cnt += int'(cell_at(g, r + dr, c + dc));
                n[r][c] = g[r][c] ? s[cnt] : b[cnt];
            end
        end
    endtask

    task automatic push_expected(input grid_t n);
`ifdef GOL_TORUS_EN
        for (int i = 1; i < int'(H); i++) exp_q.push_back('{row: n[i], idx: i, last: 1'b0});
        exp_q.push_back('{row: n[0], idx: 0, last: 1'b1});
`else
        for (int i = 0; i < int'(H); i++)
            exp_q.push_back('{row: n[i], idx: i, last: (i == int'(H) - 1)});
`endif
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    // Output checker: every handshake against the model, and stability while stalled.
    always @(negedge clk) begin
        if (!rst_n || ignore_out) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_row", out_row, held_row);
                check("hold_idx", out_idx, held_idx);
                check("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_row: got idx %0d row %0h, required no output",
                             out_idx, out_row);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("row[%0d]", e.idx), out_row, e.row);
                    check($sformatf("idx[%0d]", e.idx), out_idx, e.idx);
                    check($sformatf("last[%0d]", e.idx), out_last, e.last);
                end
                cap[out_idx] = out_row;
            end
            hold_pending = out_valid && !out_ready;
            held_row     = out_row;
            held_idx     = out_idx;
            held_last    = out_last;
        end
    end

    task automatic send_frame(input grid_t g, input logic [8:0] b, input logic [8:0] s,
                              input int stall_at, input bit scramble, input bit bub,
                              input int nrows);
        grid_t n;
        int    waited;
        int    saved;
        if (nrows == int'(H)) begin
            next_gen(g, b, s, n);
            push_expected(n);
        end
        tick();
        birth_mask   = b;
        survive_mask = s;
        for (int r = 0; r < nrows; r++) begin
            if (bub) repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_row   = g[r];
            waited   = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                tick();
                waited++;
                if (waited > 200) begin
                    check("in_ready_timeout", in_ready, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
            tick();
            in_valid = 1'b0;
            if (scramble && r == 0) begin
                birth_mask   = GOL_B3S23_BIRTH;
                survive_mask = GOL_B3S23_SURVIVE;
            end
            if (r == stall_at && r + 1 < nrows) begin
                in_valid  = 1'b1;
                in_row    = g[r+1];
                out_ready = 1'b0;
                saved     = rdy_mode;
                rdy_mode  = 2;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    if (i == 4) rdy_mode = saved;
                    tick();
                end
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int w = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && w < 300) begin
            tick();
            w++;
        end
        tick();
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic clear_cap();
        for (int i = 0; i < int'(H); i++) cap[i] = 'x;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        grid_t g;
        grid_t zero;
        grid_t n;
        for (int i = 0; i < int'(H); i++) zero[i] = '0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("fill_in_ready", in_ready, 1);
        ignore_out = 1'b0;

        // 1. Vertical blinker becomes horizontal
        g = zero;
        g[2] = 8'h08; g[3] = 8'h08; g[4] = 8'h08;
        clear_cap();
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, int'(H));
        drain();
        check("blinker_r2", cap[2], 8'h00);
        check("blinker_r3", cap[3], 8'h1C);
        check("blinker_r4", cap[4], 8'h00);

        // 2. Corner block is a still life
        g = zero;
        g[0] = 8'h03; g[1] = 8'h03;
        clear_cap();
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, int'(H));
        drain();
        check("block_r0", cap[0], 8'h03);
        check("block_r1", cap[1], 8'h03);
        check("block_r2", cap[2], 8'h00);

        // 3. Birth on any neighbour, no survival; masks changed mid-frame are ignored
        g = zero;
        g[4] = 8'h10;
        clear_cap();
        send_frame(g, 9'h1FE, 9'h000, -1, 1'b1, 1'b0, int'(H));
        drain();
        check("ring_r3", cap[3], 8'h38);
        check("ring_r4", cap[4], 8'h28);
        check("ring_r5", cap[5], 8'h38);
        check("ring_r6", cap[6], 8'h00);

        // 4. Five-cycle output stall mid-frame, then random bubbles on both sides
        for (int i = 0; i < int'(H); i++) g[i] = W'($urandom);
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, 3, 1'b0, 1'b0, int'(H));
        drain();
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < int'(H); i++) g[i] = W'($urandom);
            send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b1, int'(H));
        end
        drain();
        rdy_mode = 0;

        // 5. Reset after four rows, then a fresh frame (glider across the bottom edge)
        ignore_out = 1'b1;
        for (int i = 0; i < int'(H); i++) g[i] = 8'hFF;
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, 4);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        exp_q.delete();
        ignore_out = 1'b0;
        tick();
        g = zero;
        g[6] = 8'h08; g[7] = 8'h10; g[0] = 8'h1C;
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, int'(H));
        drain();

        // 6. All-ones frame followed back-to-back by an all-zero frame
        for (int i = 0; i < int'(H); i++) g[i] = 8'hFF;
        next_gen(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, n);
`ifdef GOL_TORUS_EN
        check("model_ones_r0", n[0], 8'h00);
        check("model_ones_r3", n[3], 8'h00);
`else
        check("model_ones_r0", n[0], 8'h81);
        check("model_ones_r3", n[3], 8'h00);
        check("model_ones_r7", n[7], 8'h81);
`endif
        send_frame(g, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, int'(H));
        clear_cap();
        send_frame(zero, GOL_B3S23_BIRTH, GOL_B3S23_SURVIVE, -1, 1'b0, 1'b0, int'(H));
        drain();
        check("zero_r0", cap[0], 8'h00);
        check("zero_r7", cap[7], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
